pmod_kypd_emulator: RTL

PMOD_KYPD_EMULATOR -- requirements
Module: pmod_kypd_emulator

---
 rtl/pmod_kypd_emulator.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/pmod_kypd_emulator.sv
// pmod_kypd_emulator
// Emulates a Digilent Pmod KYPD 4x4 keypad toward a host that scans columns
// (active-low Col strobes) and samples rows (active-low Row response).
// One key press is requested at a time through key_req/key_code/key_hold.
// The key stays pressed for key_hold strobes of its column; a watchdog
// aborts the press if the column is not strobed for TIMEOUT_CYCLES cycles.
//
// Build option: define KYPD_COL_SYNC_EN to place a two-flop synchronizer on
// Col (Row latency becomes 3 cycles instead of 1).

module pmod_kypd_emulator #(
    parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Col,
    output logic [3:0] Row,
    input  logic       key_req,
    input  logic [3:0] key_code,
    input  logic [7:0] key_hold,
    output logic       key_ready,
    output logic       key_done,
    output logic       key_timeout,
    output logic       scan_err
);

    // state   | meaning
    // IDLE    | no key pressed, Row released, accepting key_req
    // PRESSED | latched key answers strobes of its column until done/timeout
    typedef enum logic {
        IDLE    = 1'b0,
        PRESSED = 1'b1
    } state_e;

    // Watchdog only needs to reach TIMEOUT_CYCLES-1 before the press aborts.
    localparam int unsigned WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] PAT_NONE = 4'b1111;
    localparam logic [3:0] PAT_1    = 4'b0111;
    localparam logic [3:0] PAT_2    = 4'b1011;
    localparam logic [3:0] PAT_3    = 4'b1101;
    localparam logic [3:0] PAT_4    = 4'b1110;

    // Column carrying a key: 1/4/7/0 | 2/5/8/F | 3/6/9/E | A/B/C/D.
    function automatic logic [3:0] col_of(input logic [3:0] code);
        logic [3:0] pat;
        case (code)
            4'h1, 4'h4, 4'h7, 4'h0: pat = PAT_1;
            4'h2, 4'h5, 4'h8, 4'hF: pat = PAT_2;
            4'h3, 4'h6, 4'h9, 4'hE: pat = PAT_3;
            default:                pat = PAT_4;
        endcase
        return pat;
    endfunction

    // Row carrying a key: position of the key within its column, top to bottom.
    function automatic logic [3:0] row_of(input logic [3:0] code);
        logic [3:0] pat;
        case (code)
            4'h1, 4'h2, 4'h3, 4'hA: pat = PAT_1;
            4'h4, 4'h5, 4'h6, 4'hB: pat = PAT_2;
            4'h7, 4'h8, 4'h9, 4'hC: pat = PAT_3;
            default:                pat = PAT_4;
        endcase
        return pat;
    endfunction

    state_e          state_q, state_d;
    logic [3:0]      code_q;
    logic [7:0]      hold_q;
    logic [7:0]      strb_cnt_q;
    logic [WD_W-1:0] wd_q;
    logic [3:0]      colv_prev_q;
    logic [3:0]      row_q, row_d;
    logic            scan_err_q;

    logic [3:0]      colv;
    logic [3:0]      lat_col;
    logic [3:0]      lat_row;
    logic [7:0]      hold_min;
    logic            col_match;
    logic            strobe;
    logic            exit_norm;
    logic            wd_expired;
    logic            col_illegal;

`ifdef KYPD_COL_SYNC_EN
    logic [3:0] col_s1_q;
    logic [3:0] col_s2_q;

    // Two-flop synchronizer for the asynchronous column strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_s1_q <= PAT_NONE;
            col_s2_q <= PAT_NONE;
        end else begin
            col_s1_q <= Col;
            col_s2_q <= col_s1_q;
        end
    end

    assign colv = col_s2_q;
`else
    assign colv = Col;
`endif

    // Decode of the latched key and the strobe / exit conditions derived from it.
    always_comb begin
        lat_col     = col_of(code_q);
        lat_row     = row_of(code_q);
        hold_min    = (hold_q == 8'd0) ? 8'd1 : hold_q;
        col_match   = (colv == lat_col);
        strobe      = (state_q == PRESSED) && col_match && (colv_prev_q != lat_col);
        exit_norm   = (state_q == PRESSED) && (strb_cnt_q >= hold_min) && !col_match;
        wd_expired  = (state_q == PRESSED) && (wd_q == WD_LAST);
        col_illegal = !((colv == PAT_NONE) || (colv == PAT_1) || (colv == PAT_2) ||
                        (colv == PAT_3) || (colv == PAT_4));
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; key_req is only looked at while idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (key_req) begin
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                if (exit_norm || wd_expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; a normal exit masks a watchdog expiry in the same cycle.
    always_comb begin
        key_ready   = (state_q == IDLE);
        key_done    = exit_norm;
        key_timeout = wd_expired && !exit_norm;
    end

    // Row answer for the next cycle; released as soon as the press ends.
    always_comb begin
        row_d = PAT_NONE;
        if ((state_q == PRESSED) && (state_d == PRESSED) && col_match) begin
            row_d = lat_row;
        end
    end

    // Key latch, strobe counter and watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q     <= 4'h0;
            hold_q     <= 8'h00;
            strb_cnt_q <= 8'h00;
            wd_q       <= '0;
        end else if (state_q == IDLE) begin
            if (key_req) begin
                code_q <= key_code;
                hold_q <= key_hold;
            end
            strb_cnt_q <= 8'h00;
            wd_q       <= '0;
        end else if (strobe) begin
            if (strb_cnt_q != 8'hFF) begin
                strb_cnt_q <= strb_cnt_q + 8'd1;
            end
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end

    // Column history, registered Row and sticky illegal-scan flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colv_prev_q <= PAT_NONE;
            row_q       <= PAT_NONE;
            scan_err_q  <= 1'b0;
        end else begin
            colv_prev_q <= colv;
            row_q       <= row_d;
            scan_err_q  <= scan_err_q | col_illegal;
        end
    end

    assign Row      = row_q;
    assign scan_err = scan_err_q;

endmodule
